adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined adder/subtractor, successor to the fixed 64-bit four-group carry-chained adder. It splits a WIDTH-bit operation into WIDTH/GROUP carry-linked groups and computes one group per pipeline stage, with the carry registered between stages. Throughput is one operation per clock and latency is WIDTH/GROUP cycles. It sits in the datapath behind a valid/ready handshake, with full backpressure.

## Interface
- WIDTH, 64: operand width; must be a multiple of GROUP, and WIDTH ≥ GROUP.
- GROUP, 16: bits computed per stage. Number of stages NS = WIDTH/GROUP.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk edge).
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a, b  in  WIDTH each  operands (two's complement for the overflow flag).
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = a+b+cin, 1 = a−b−cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Sub mode uses the operand b' = ~b and the carry-in c' = ~cin. Add mode uses b' = b and c' = cin.
- Stage k (0..NS−1) adds group k: bits [k·GROUP+GROUP−1 : k·GROUP] of a and b'. Its carry-in is the registered carry from stage k−1; stage 0 uses c'.
- Each stage register holds:
  - valid;
  - the sum groups computed so far;
  - the still-unprocessed upper groups of a and b';
  - the carry;
  - for the last stage only, the ovf inputs.
- ovf = carry into MSB XOR carry out of MSB, taken from the top group. cout = carry out of the top group.
- zero is computed combinationally from the registered output sum. No extra cycle.
- Pipeline advance: a single global enable, en = !out_valid || out_ready.
  - in_ready = en.
  - A beat is accepted when in_valid && in_ready.
  - When en = 1, every stage loads from its predecessor. Stage 0 loads the accept condition as its valid.
  - When en = 0, every stage holds: no bubble is removed and no data is lost.
- Bubbles propagate as valid = 0. Data registers of invalid stages are don't-care, but sum/cout/ovf must not change while out_valid = 1 and out_ready = 0.

## Timing
- Reset (rst_n = 0 at a rising edge) clears every stage valid, sum, cout and ovf to 0. Results are:
  - out_valid = 0, sum = 0, cout = 0, ovf = 0;
  - zero = 1;
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Nothing is emitted for them.
- Latency: a beat accepted at edge t has out_valid = 1 after edge t+NS−1. The output register is the stage NS−1 register. NS = 1 means 1 cycle.
- Throughput: with out_ready held at 1, one result per cycle, back-to-back, in order.
- Stall: out_valid = 1 with out_ready = 0 gives in_ready = 0 in the same cycle (combinational path out_ready → in_ready). The output and all stages hold.
- Simultaneous pop and push: out_valid && out_ready && in_valid accepts the new beat and advances all stages in the same cycle.
- Wrap-around: sum wraps modulo 2^WIDTH. Carry and overflow are reported only via cout and ovf, never by widening sum.

## Structure
- Package adder_pipe_pkg holds:
  - default WIDTH and GROUP constants;
  - the mode encoding constants MODE_ADD = 0 and MODE_SUB = 1;
  - a function computing NS with an elaboration-time check that WIDTH % GROUP == 0.
- Sub-module adder_group: a combinational GROUP-bit adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, and the carry into its MSB (for ovf).
  - Instantiated NS times through a generate loop.
- The stage registers stay in adder_pipe. There is no FSM beyond the per-stage valid bits.

## Test plan
- Reset, then idle (WIDTH=64, GROUP=16):
  - right after reset: out_valid=0, sum=0, zero=1, in_ready=1.
  - assert reset while 3 beats are in flight: no result ever appears for them.
- Add with full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 → after 4 cycles sum=0, cout=1, ovf=0, zero=1.
- Signed overflow:
  - a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add → sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
  - a=64'h8000_0000_0000_0000 minus 1, sub, cin=0 → ovf=1, cout=1.
- Subtract with borrow:
  - a=5, b=7, sub=1, cin=1 → sum=64'hFFFF_FFFF_FFFF_FFFD (−3), cout=0.
  - a=7, b=5, cin=0 → sum=2, cout=1.
- Backpressure: stream 10 random beats with in_valid always 1 and out_ready toggling by a random pattern. Check:
  - results arrive in order and equal a reference model;
  - outputs stay stable while stalled;
  - in_ready == (!out_valid || out_ready) every cycle;
  - with out_ready=1 constantly, 10 results arrive in 10 consecutive cycles.
- Parameter sweep: repeat random add/sub against the reference model for (WIDTH, GROUP) = (16,16), (32,8), (128,32). Check latency is 1, 4 and 4 cycles respectively.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_pkg
// Purpose  : Shared constants and stage-count helper for the pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pipe_pkg;

  localparam int   DEF_WIDTH = 64;
  localparam int   DEF_GROUP = 16;

  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SUB  = 1'b1;

  // Returns 0 for an illegal split so the instantiating module can reject it.
  function automatic int calc_ns(input int width, input int group);
    if (group < 1 || width < group || (width % group) != 0) return 0;
    return width / group;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_group.sv
`default_nettype none
// ============================================================================
// Module   : adder_group
// Purpose  : Combinational GROUP-bit adder slice with carry into its MSB.
// Revision : 1.0 - initial release
// ============================================================================
module adder_group
  import adder_pipe_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [GROUP:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{GROUP{1'b0}}, ci};
  assign s      = w_full[GROUP-1:0];
  assign co     = w_full[GROUP];
  // The MSB sum bit is a^b^carry-in, so the carry into the MSB falls out directly.
  assign cmsb   = a[GROUP-1] ^ b[GROUP-1] ^ w_full[GROUP-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Pipelined add/sub, one GROUP-bit slice per stage, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NS = calc_ns(WIDTH, GROUP);

  if (NS == 0) begin : g_bad_split
    $error("adder_pipe: WIDTH must be a positive multiple of GROUP");
  end

  logic             w_en;
  logic             w_accept;
  logic [WIDTH-1:0] w_bp;
  logic             w_cp;

  logic [NS-1:0]    r_v;
  logic [NS-1:0]    r_c;
  logic [WIDTH-1:0] r_s [NS];
  logic [WIDTH-1:0] r_a [NS];
  logic [WIDTH-1:0] r_b [NS];
  logic             r_ovf;

  logic [GROUP-1:0] w_ga [NS];
  logic [GROUP-1:0] w_gb [NS];
  logic [GROUP-1:0] w_gs [NS];
  logic [NS-1:0]    w_gci;
  logic [NS-1:0]    w_gco;
  logic             w_gcm [NS];

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign w_en     = !r_v[NS-1] || out_ready;
  assign w_accept = in_valid && w_en;
  assign in_ready = w_en;

  assign w_bp = (sub == MODE_SUB) ? ~b   : b;
  assign w_cp = (sub == MODE_SUB) ? ~cin : cin;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_ga[k]  = a[GROUP-1:0];
      assign w_gb[k]  = w_bp[GROUP-1:0];
      assign w_gci[k] = w_cp;
    end else begin : g_tail
      assign w_ga[k]  = r_a[k-1][k*GROUP +: GROUP];
      assign w_gb[k]  = r_b[k-1][k*GROUP +: GROUP];
      assign w_gci[k] = r_c[k-1];
    end

    adder_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a    (w_ga[k]),
      .b    (w_gb[k]),
      .ci   (w_gci[k]),
      .s    (w_gs[k]),
      .co   (w_gco[k]),
      .cmsb (w_gcm[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        r_s[k] <= '0;
      end
    end else if (w_en) begin
      r_v[0]             <= w_accept;
      r_s[0][GROUP-1:0]  <= w_gs[0];
      r_a[0]             <= a;
      r_b[0]             <= w_bp;
      r_c[0]             <= w_gco[0];
      for (int k = 1; k < NS; k++) begin
        r_v[k]                  <= r_v[k-1];
        r_s[k]                  <= r_s[k-1];
        r_s[k][k*GROUP +: GROUP] <= w_gs[k];
        r_a[k]                  <= r_a[k-1];
        r_b[k]                  <= r_b[k-1];
        r_c[k]                  <= w_gco[k];
      end
      r_ovf <= w_gcm[NS-1] ^ w_gco[NS-1];
    end
  end

  assign out_valid = r_v[NS-1];
  assign sum       = r_s[NS-1];
  assign cout      = r_c[NS-1];
  assign ovf       = r_ovf;
  assign zero      = (r_s[NS-1] == '0);

endmodule
`default_nettype wire
